conv_controller: RTL and testbench

- Sequencer for one convolution layer held in a single-port BRAM. It walks the full loop nest: output channel, output row, output column, input channel, kernel row, kernel column.
- For each kernel tap it reads one weight and one input byte and accumulates their Q4.4 fixed-point product.
- For each output pixel it writes one saturated, optionally ReLU'd byte back to the BRAM.
- It sits between the top-level start/configuration registers and the BRAM port.

---
 rtl/conv_controller_if.sv | 54 +++++
 rtl/conv_controller.sv | 211 +++++++++++++++++++++
 tb/tb_conv_controller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_controller_if.sv
// Bundles the configuration, BRAM port and status signals of the convolution sequencer.
// The master side is the controller; the slave side is the config registers, BRAM and observer.
interface conv_controller_if #(
    parameter int width      = 8,
    parameter int memaddrbit = 14
) ();
    logic                  start_i;
    logic [memaddrbit-1:0] do_i;
    logic [memaddrbit-1:0] di_i;
    logic [memaddrbit-1:0] dr_i;
    logic [memaddrbit-1:0] dc_i;
    logic [memaddrbit-1:0] dkr_i;
    logic [memaddrbit-1:0] dkc_i;
    logic [memaddrbit-1:0] dr_out_i;
    logic [memaddrbit-1:0] dc_out_i;
    logic [2:0]            step_i;
    logic                  relu_i;
    logic [memaddrbit-1:0] inaddr_i;
    logic [memaddrbit-1:0] waddr_i;
    logic [memaddrbit-1:0] outaddr_i;
    logic                  checkbram_i;
    logic [memaddrbit-1:0] memaddr_check_i;
    logic [width-1:0]      mem_out_i;

    logic                  wea_o;
    logic [memaddrbit-1:0] memaddr_o;
    logic [width-1:0]      mem_in_o;
    logic [7:0]            state_o;
    logic [memaddrbit-1:0] io_o;
    logic [memaddrbit-1:0] ii_o;
    logic [memaddrbit-1:0] ir_o;
    logic [memaddrbit-1:0] ic_o;
    logic [memaddrbit-1:0] ikr_o;
    logic [memaddrbit-1:0] ikc_o;
    logic                  pixel_finish_o;
    logic                  filter_finish_o;
    logic                  picture_finish_o;

    modport master (
        input  start_i, do_i, di_i, dr_i, dc_i, dkr_i, dkc_i, dr_out_i, dc_out_i,
               step_i, relu_i, inaddr_i, waddr_i, outaddr_i, checkbram_i,
               memaddr_check_i, mem_out_i,
        output wea_o, memaddr_o, mem_in_o, state_o, io_o, ii_o, ir_o, ic_o,
               ikr_o, ikc_o, pixel_finish_o, filter_finish_o, picture_finish_o
    );

    modport slave (
        output start_i, do_i, di_i, dr_i, dc_i, dkr_i, dkc_i, dr_out_i, dc_out_i,
               step_i, relu_i, inaddr_i, waddr_i, outaddr_i, checkbram_i,
               memaddr_check_i, mem_out_i,
        input  wea_o, memaddr_o, mem_in_o, state_o, io_o, ii_o, ir_o, ic_o,
               ikr_o, ikc_o, pixel_finish_o, filter_finish_o, picture_finish_o
    );
endinterface

// File: rtl/conv_controller.sv
// Convolution layer sequencer: walks the full loop nest over a single-port BRAM,
// accumulating Q4.4 products and writing one saturated (optionally ReLU'd) byte per pixel.
module conv_controller #(
    parameter int width      = 8,
    parameter int decimal    = 4,
    parameter int memaddrbit = 14
) (
    input logic               clk,
    input logic               rst,
    conv_controller_if.master bus
);
    localparam int AccW  = 24;
    localparam int ProdW = 2 * width;

    typedef logic [memaddrbit-1:0] addr_t;
    localparam addr_t One = addr_t'(1);
    localparam logic signed [AccW-1:0] SatMax = AccW'((1 << (width - 1)) - 1);
    localparam logic signed [AccW-1:0] SatMin = ~SatMax;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_W  = 3'd1,
        RD_IN = 3'd2,
        MAC   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;
    addr_t  do_q, di_q, dr_q, dc_q, dkr_q, dkc_q, drOut_q, dcOut_q, step_q;
    addr_t  inaddr_q, waddr_q, outaddr_q;
    logic   relu_q;
    addr_t  io_q, io_d, ii_q, ii_d, ir_q, ir_d, ic_q, ic_d, ikr_q, ikr_d, ikc_q, ikc_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [width-1:0] weight_q, weight_d, memIn_q, memIn_d;
    logic   latchCfg;

    // A zero loop limit would never terminate, so it behaves as a single iteration.
    function automatic addr_t atLeastOne(input addr_t v);
        return (v == '0) ? One : v;
    endfunction

    addr_t wAddr, inAddr, outAddr, stepIn;
    assign stepIn  = addr_t'(bus.step_i);
    assign wAddr   = waddr_q + ((io_q * di_q + ii_q) * dkr_q + ikr_q) * dkc_q + ikc_q;
    assign inAddr  = inaddr_q + ii_q * dr_q * dc_q + (ir_q * step_q + ikr_q) * dc_q
                     + (ic_q * step_q + ikc_q);
    assign outAddr = outaddr_q + io_q * drOut_q * dcOut_q + ir_q * dcOut_q + ic_q;

    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0]  prodExt, shifted;
    logic [width-1:0]        satVal, result;
    assign prod    = $signed(weight_q) * $signed(bus.mem_out_i);
    assign prodExt = {{(AccW - ProdW){prod[ProdW-1]}}, prod};
    assign shifted = acc_q >>> decimal;

    always_comb begin
        if (shifted > SatMax)      satVal = SatMax[width-1:0];
        else if (shifted < SatMin) satVal = SatMin[width-1:0];
        else                       satVal = shifted[width-1:0];
        result = (relu_q && satVal[width-1]) ? '0 : satVal;
    end

    logic ikcLast, ikrLast, iiLast, icLast, irLast, ioLast;
    assign ikcLast = (ikc_q == dkc_q - One);
    assign ikrLast = (ikr_q == dkr_q - One);
    assign iiLast  = (ii_q == di_q - One);
    assign icLast  = (ic_q == dcOut_q - One);
    assign irLast  = (ir_q == drOut_q - One);
    assign ioLast  = (io_q == do_q - One);

    always_comb begin
        state_d  = state_q;
        io_d     = io_q;
        ii_d     = ii_q;
        ir_d     = ir_q;
        ic_d     = ic_q;
        ikr_d    = ikr_q;
        ikc_d    = ikc_q;
        acc_d    = acc_q;
        weight_d = weight_q;
        memIn_d  = memIn_q;
        latchCfg = 1'b0;
        bus.wea_o            = 1'b0;
        bus.memaddr_o        = '0;
        bus.mem_in_o         = memIn_q;
        bus.pixel_finish_o   = 1'b0;
        bus.filter_finish_o  = 1'b0;
        bus.picture_finish_o = 1'b0;
        case (state_q)
            IDLE: begin
                bus.memaddr_o = bus.checkbram_i ? bus.memaddr_check_i : '0;
                if (bus.start_i) begin
                    io_d     = '0;
                    ii_d     = '0;
                    ir_d     = '0;
                    ic_d     = '0;
                    ikr_d    = '0;
                    ikc_d    = '0;
                    acc_d    = '0;
                    latchCfg = 1'b1;
                    state_d  = RD_W;
                end
            end
            RD_W: begin
                bus.memaddr_o = wAddr;
                state_d       = RD_IN;
            end
            RD_IN: begin
                bus.memaddr_o = inAddr;
                weight_d      = bus.mem_out_i;
                state_d       = MAC;
            end
            MAC: begin
                acc_d = acc_q + prodExt;
                ikc_d = ikcLast ? '0 : ikc_q + One;
                if (ikcLast) begin
                    ikr_d = ikrLast ? '0 : ikr_q + One;
                    if (ikrLast) ii_d = iiLast ? '0 : ii_q + One;
                end
                state_d = (ikcLast && ikrLast && iiLast) ? WRITE : RD_W;
            end
            WRITE: begin
                bus.wea_o          = 1'b1;
                bus.memaddr_o      = outAddr;
                bus.mem_in_o       = result;
                bus.pixel_finish_o = 1'b1;
                memIn_d            = result;
                acc_d              = '0;
                ic_d = icLast ? '0 : ic_q + One;
                if (icLast) begin
                    ir_d = irLast ? '0 : ir_q + One;
                    if (irLast) io_d = ioLast ? '0 : io_q + One;
                end
                bus.filter_finish_o = icLast && irLast;
                state_d = (icLast && irLast && ioLast) ? DONE : RD_W;
            end
            DONE: begin
                bus.picture_finish_o = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            io_q     <= '0;
            ii_q     <= '0;
            ir_q     <= '0;
            ic_q     <= '0;
            ikr_q    <= '0;
            ikc_q    <= '0;
            acc_q    <= '0;
            weight_q <= '0;
            memIn_q  <= '0;
        end else begin
            state_q  <= state_d;
            io_q     <= io_d;
            ii_q     <= ii_d;
            ir_q     <= ir_d;
            ic_q     <= ic_d;
            ikr_q    <= ikr_d;
            ikc_q    <= ikc_d;
            acc_q    <= acc_d;
            weight_q <= weight_d;
            memIn_q  <= memIn_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            do_q      <= One;
            di_q      <= One;
            dr_q      <= One;
            dc_q      <= One;
            dkr_q     <= One;
            dkc_q     <= One;
            drOut_q   <= One;
            dcOut_q   <= One;
            step_q    <= One;
            relu_q    <= 1'b0;
            inaddr_q  <= '0;
            waddr_q   <= '0;
            outaddr_q <= '0;
        end else if (latchCfg) begin
            do_q      <= atLeastOne(bus.do_i);
            di_q      <= atLeastOne(bus.di_i);
            dr_q      <= atLeastOne(bus.dr_i);
            dc_q      <= atLeastOne(bus.dc_i);
            dkr_q     <= atLeastOne(bus.dkr_i);
            dkc_q     <= atLeastOne(bus.dkc_i);
            drOut_q   <= atLeastOne(bus.dr_out_i);
            dcOut_q   <= atLeastOne(bus.dc_out_i);
            step_q    <= atLeastOne(stepIn);
            relu_q    <= bus.relu_i;
            inaddr_q  <= bus.inaddr_i;
            waddr_q   <= bus.waddr_i;
            outaddr_q <= bus.outaddr_i;
        end
    end

    assign bus.state_o = {5'b0, state_q};
    assign bus.io_o    = io_q;
    assign bus.ii_o    = ii_q;
    assign bus.ir_o    = ir_q;
    assign bus.ic_o    = ic_q;
    assign bus.ikr_o   = ikr_q;
    assign bus.ikc_o   = ikc_q;
endmodule

// File: tb/tb_conv_controller.sv
// Directed bench for conv_controller: a BRAM model returns constant weight/input
// patterns per region, and each layer run is checked against hand-computed results.
module tb_conv_controller;
    logic clk = 1'b0;
    logic rst;

    conv_controller_if #(.width(8), .memaddrbit(14)) bus ();

    conv_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int wBase, wLen, wVal, inBase, inLen, inVal;
    int assertCount = 0;
    int failCount   = 0;
    int writeCount, filterCount, pixelCount, pictureCount;
    int firstWriteCycle, pictureCycle, probeAddr, firstRdAddr, badData;
    int writeAddr [32];
    int writeData [32];

    // Read-only BRAM model: weight and input regions hold one constant each, everything else is 0.
    function automatic logic [7:0] romValue(input int a);
        if (a >= wBase && a < wBase + wLen)   return 8'(wVal);
        if (a >= inBase && a < inBase + inLen) return 8'(inVal);
        return 8'h00;
    endfunction

    always @(posedge clk) bus.mem_out_i <= romValue(int'(bus.memaddr_o));

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int nDo, input int nDi, input int nDr, input int nDc,
                                 input int nDkr, input int nDkc, input int nDrOut,
                                 input int nDcOut, input int nStep, input int nRelu,
                                 input int nIn, input int nW, input int nOut);
        @(negedge clk);
        bus.do_i      = 14'(nDo);
        bus.di_i      = 14'(nDi);
        bus.dr_i      = 14'(nDr);
        bus.dc_i      = 14'(nDc);
        bus.dkr_i     = 14'(nDkr);
        bus.dkc_i     = 14'(nDkc);
        bus.dr_out_i  = 14'(nDrOut);
        bus.dc_out_i  = 14'(nDcOut);
        bus.step_i    = 3'(nStep);
        bus.relu_i    = nRelu[0];
        bus.inaddr_i  = 14'(nIn);
        bus.waddr_i   = 14'(nW);
        bus.outaddr_i = 14'(nOut);
        bus.start_i   = 1'b1;
        @(negedge clk);
        bus.start_i   = 1'b0;
    endtask

    // Observes one layer; cycle 1 is the first cycle after the start edge.
    task automatic runLayer(input int maxCycles, input int pulseAt);
        int  cycle;
        bit  done;
        done = 1'b0;
        writeCount = 0; filterCount = 0; pixelCount = 0; pictureCount = 0;
        firstWriteCycle = -1; pictureCycle = -1; probeAddr = -1; firstRdAddr = -1;
        for (cycle = 1; cycle <= maxCycles && !done; cycle++) begin
            if (cycle > 1) @(negedge clk);
            bus.start_i = (cycle == pulseAt);
            if (cycle == 1) firstRdAddr = int'(bus.memaddr_o);
            if (bus.state_o == 8'd2 && bus.ir_o == 14'd1 && bus.ic_o == 14'd1 && probeAddr < 0)
                probeAddr = int'(bus.memaddr_o);
            if (bus.wea_o) begin
                if (writeCount < 32) begin
                    writeAddr[writeCount] = int'(bus.memaddr_o);
                    writeData[writeCount] = int'(bus.mem_in_o);
                end
                if (firstWriteCycle < 0) firstWriteCycle = cycle;
                writeCount++;
            end
            if (bus.pixel_finish_o)  pixelCount++;
            if (bus.filter_finish_o) filterCount++;
            if (bus.picture_finish_o) begin
                pictureCount++;
                pictureCycle = cycle;
                done = 1'b1;
            end
        end
        bus.start_i = 1'b0;
        checkOutput("layerDone", int'(done), 1);
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        bus.start_i = 1'b0; bus.checkbram_i = 1'b0; bus.memaddr_check_i = '0;
        bus.do_i = '0; bus.di_i = '0; bus.dr_i = '0; bus.dc_i = '0;
        bus.dkr_i = '0; bus.dkc_i = '0; bus.dr_out_i = '0; bus.dc_out_i = '0;
        bus.step_i = '0; bus.relu_i = 1'b0;
        bus.inaddr_i = '0; bus.waddr_i = '0; bus.outaddr_i = '0;
        wBase = 0; wLen = 0; wVal = 0; inBase = 0; inLen = 0; inVal = 0;
        repeat (3) @(negedge clk);
        checkOutput("resetState", int'(bus.state_o), 0);
        checkOutput("resetMemaddr", int'(bus.memaddr_o), 0);
        checkOutput("resetWea", int'(bus.wea_o), 0);
        checkOutput("resetIkc", int'(bus.ikc_o), 0);
        rst = 1'b1;

        $display("[TB] basic 3x3 layer");
        wBase = 50; wLen = 9; wVal = 8'h10; inBase = 10; inLen = 9; inVal = 8'h08;
        applyStimulus(1, 1, 3, 3, 3, 3, 1, 1, 1, 0, 10, 50, 100);
        runLayer(100, 0);
        checkOutput("basicFirstRd", firstRdAddr, 50);
        checkOutput("basicWrites", writeCount, 1);
        checkOutput("basicWriteCycle", firstWriteCycle, 28);
        checkOutput("basicAddr", writeAddr[0], 100);
        checkOutput("basicData", writeData[0], 8'h48);
        checkOutput("basicPicCycle", pictureCycle, 29);
        checkOutput("basicFilter", filterCount, 1);

        $display("[TB] negative saturation, relu changed after start and a stray start");
        wVal = 8'hF0; inVal = 8'h10;
        applyStimulus(1, 1, 3, 3, 3, 3, 1, 1, 1, 0, 10, 50, 100);
        bus.relu_i = 1'b1;
        bus.outaddr_i = 14'd777;
        runLayer(100, 5);
        checkOutput("satWrites", writeCount, 1);
        checkOutput("satData", writeData[0], 8'h80);
        checkOutput("satAddr", writeAddr[0], 100);
        checkOutput("satPicCycle", pictureCycle, 29);

        $display("[TB] relu clamp");
        applyStimulus(1, 1, 3, 3, 3, 3, 1, 1, 1, 1, 10, 50, 100);
        runLayer(100, 0);
        checkOutput("reluData", writeData[0], 0);

        $display("[TB] stride 2 on a 5x5 input");
        wBase = 300; wLen = 9; wVal = 8'h10; inBase = 2; inLen = 25; inVal = 8'h04;
        applyStimulus(1, 1, 5, 5, 3, 3, 2, 2, 2, 0, 2, 300, 500);
        runLayer(300, 0);
        checkOutput("strideProbe", probeAddr, 14);
        checkOutput("strideWrites", writeCount, 4);
        checkOutput("strideFilter", filterCount, 1);
        checkOutput("stridePixels", pixelCount, 4);
        checkOutput("stridePicCycle", pictureCycle, 113);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("strideAddr%0d", k), writeAddr[k], 500 + k);
            checkOutput($sformatf("strideData%0d", k), writeData[k], 8'h24);
        end

        $display("[TB] multi-channel layer with output address wrap");
        wBase = 200; wLen = 16; wVal = 8'h10; inBase = 100; inLen = 32; inVal = 8'h08;
        applyStimulus(2, 2, 4, 4, 2, 2, 3, 3, 1, 0, 100, 200, 16380);
        runLayer(1000, 0);
        checkOutput("multiWrites", writeCount, 18);
        checkOutput("multiFilter", filterCount, 2);
        checkOutput("multiPicCycle", pictureCycle, 451);
        checkOutput("multiFirstAddr", writeAddr[0], 16380);
        checkOutput("multiAddr3", writeAddr[3], 16383);
        checkOutput("multiAddr4", writeAddr[4], 0);
        checkOutput("multiLastAddr", writeAddr[17], 13);
        badData = 0;
        for (int k = 0; k < 18; k++) if (writeData[k] != 8'h40) badData++;
        checkOutput("multiBadData", badData, 0);

        $display("[TB] zero limits behave as one");
        wBase = 300; wLen = 1; wVal = 8'h20; inBase = 2; inLen = 1; inVal = 8'h18;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 300, 600);
        runLayer(50, 0);
        checkOutput("zeroWrites", writeCount, 1);
        checkOutput("zeroData", writeData[0], 8'h30);
        checkOutput("zeroAddr", writeAddr[0], 600);
        checkOutput("zeroPicCycle", pictureCycle, 5);

        $display("[TB] reset during MAC, then debug read");
        wBase = 50; wLen = 9; wVal = 8'h10; inBase = 10; inLen = 9; inVal = 8'h08;
        applyStimulus(1, 1, 3, 3, 3, 3, 1, 1, 1, 0, 10, 50, 100);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus.state_o == 8'd3 && bus.ikc_o == 14'd1) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("reachMac", int'(found), 1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midResetState", int'(bus.state_o), 0);
        checkOutput("midResetIkc", int'(bus.ikc_o), 0);
        checkOutput("midResetIi", int'(bus.ii_o), 0);
        checkOutput("midResetWea", int'(bus.wea_o), 0);
        checkOutput("midResetMemaddr", int'(bus.memaddr_o), 0);
        rst = 1'b1;
        bus.checkbram_i = 1'b1;
        bus.memaddr_check_i = 14'd233;
        @(negedge clk);
        checkOutput("debugMemaddr", int'(bus.memaddr_o), 233);
        checkOutput("debugWea", int'(bus.wea_o), 0);
        checkOutput("debugState", int'(bus.state_o), 0);
        bus.checkbram_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
